// File: rtl/alu_issue_if.sv
// Command and response valid/ready streams of the ALU issue controller.
// master: command issuer / response consumer; slave: the controller.
interface alu_issue_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [3:0] cmd_tag;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [2:0] rsp_op;
    logic [3:0] rsp_tag;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
        input  cmd_ready,
        input  rsp_valid, rsp_data, rsp_op, rsp_tag,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
        output cmd_ready,
        output rsp_valid, rsp_data, rsp_op, rsp_tag,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Queues ALU commands, drives the ALU with a forced select toggle,
// waits SETTLE cycles, captures the result and returns it with op/tag.
// Ports: clk, rst (sync, high); bus (cmd/rsp streams, slave side);
//   alu_a/alu_b/alu_select to the ALU; alu_result from it;
//   ops_done counts completed responses (wraps).
module alu_issue_ctrl #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    alu_issue_if.slave  bus,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_select,
    input  logic [7:0]  alu_result,
    output logic [15:0] ops_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SETTLE_ST,
        RESP
    } state_t;

    cmd_t            mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      work_op_q;
    logic [3:0]      work_tag_q;
    logic [7:0]      alu_a_q;
    logic [7:0]      alu_b_q;
    logic [2:0]      alu_sel_q;
    logic            rsp_valid_q;
    logic [7:0]      rsp_data_q;
    logic [2:0]      rsp_op_q;
    logic [3:0]      rsp_tag_q;
    logic [15:0]     ops_done_q;

    cmd_t            head;
    logic            not_empty;
    logic            push;
    logic            pop;
    logic            rsp_hs;

    assign head      = mem_q[rd_ptr_q];
    assign not_empty = (count_q != '0);
    assign rsp_hs    = rsp_valid_q && bus.rsp_ready;

    // No bypass: a full queue refuses pushes even if a pop is pending.
    assign bus.cmd_ready = !rst && (count_q < (AW+1)'(DEPTH));
    assign push = bus.cmd_valid && bus.cmd_ready;

    // Head leaves the queue from IDLE, or straight after a response
    // handshake so the next command enters DRIVE without an idle cycle.
    assign pop = not_empty &&
                 ((state_q == IDLE) || (state_q == RESP && rsp_hs));

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{op:  bus.cmd_op,
                                 a:   bus.cmd_a,
                                 b:   bus.cmd_b,
                                 tag: bus.cmd_tag};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_op_q   <= '0;
            work_tag_q  <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_op_q    <= '0;
            rsp_tag_q   <= '0;
            ops_done_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        work_op_q  <= head.op;
                        work_tag_q <= head.tag;
                        alu_a_q    <= head.a;
                        alu_b_q    <= head.b;
                        // Inverted select guarantees a change before the
                        // real op, so the ALU always recomputes.
                        alu_sel_q  <= ~head.op;
                        state_q    <= DRIVE;
                    end
                end
                DRIVE: begin
                    alu_sel_q <= work_op_q;
                    cnt_q     <= CW'(SETTLE - 1);
                    state_q   <= SETTLE_ST;
                end
                SETTLE_ST: begin
                    if (cnt_q == '0) begin
                        rsp_data_q  <= alu_result;
                        rsp_op_q    <= work_op_q;
                        rsp_tag_q   <= work_tag_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        rsp_valid_q <= 1'b0;
                        ops_done_q  <= ops_done_q + 16'd1;
                        if (pop) begin
                            work_op_q  <= head.op;
                            work_tag_q <= head.tag;
                            alu_a_q    <= head.a;
                            alu_b_q    <= head.b;
                            alu_sel_q  <= ~head.op;
                            state_q    <= DRIVE;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_select    = alu_sel_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_op    = rsp_op_q;
    assign bus.rsp_tag   = rsp_tag_q;
    assign ops_done      = ops_done_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a select-triggered ALU model.
// Expected values are hand-computed constants.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_select;
    logic [7:0]  alu_result;
    logic [15:0] ops_done;

    int n_tests = 0;
    int n_fail  = 0;

    alu_issue_if bus ();

    alu_issue_ctrl #(.DEPTH(4), .SETTLE(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_select (alu_select),
        .alu_result (alu_result),
        .ops_done   (ops_done)
    );

    always #5 clk = ~clk;

    // ALU recomputes only when its select input changes.
    always @(alu_select) begin
        case (alu_select)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = alu_a ^ alu_b;
            3'b101:  alu_result = ~alu_a;
            3'b110:  alu_result = alu_a;
            default: alu_result = alu_b;
        endcase
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [2:0] op,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        input logic [3:0] tg);
        int w;
        w = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_tag   = tg;
        while (!bus.cmd_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("push_rdy", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input logic [7:0] d,
                           input logic [2:0] op,
                           input logic [3:0] tg);
        int w;
        w = 0;
        bus.rsp_ready = 1'b1;
        while (!bus.rsp_valid && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rsp_data",  32'(bus.rsp_data),  32'(d));
        check("rsp_op",    32'(bus.rsp_op),    32'(op));
        check("rsp_tag",   32'(bus.rsp_tag),   32'(tg));
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_tag   = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy",   32'(bus.cmd_ready), 32'd0);
        check("rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_data",  32'(bus.rsp_data),  32'd0);
        check("rst_tag",   32'(bus.rsp_tag),   32'd0);
        check("rst_alu_a", 32'(alu_a),         32'd0);
        check("rst_sel",   32'(alu_select),    32'd0);
        check("rst_done",  32'(ops_done),      32'd0);
        rst = 1'b0;
        #1;
        check("rdy_out", 32'(bus.cmd_ready), 32'd1);

        // Single add, latency of 4 edges
        push(3'b000, 8'h30, 8'h25, 4'd3);
        repeat (3) @(posedge clk);
        #1;
        check("lat_early", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("lat4", 32'(bus.rsp_valid), 32'd1);
        get_rsp(8'h55, 3'b000, 4'd3);
        check("done1", 32'(ops_done), 32'd1);

        // Identical ops back to back: select must toggle in DRIVE
        push(3'b000, 8'h30, 8'h25, 4'd1);
        push(3'b000, 8'h10, 8'h01, 4'd2);
        check("drv1_sel", 32'(alu_select), 32'd7);
        check("drv1_a",   32'(alu_a),      32'h30);
        get_rsp(8'h55, 3'b000, 4'd1);
        check("drv2_sel", 32'(alu_select), 32'd7);
        check("drv2_a",   32'(alu_a),      32'h10);
        get_rsp(8'h11, 3'b000, 4'd2);
        check("done3", 32'(ops_done), 32'd3);

        // Mixed ops, tags in order
        push(3'b001, 8'h10, 8'h20, 4'd5);
        push(3'b110, 8'h80, 8'h33, 4'd6);
        push(3'b111, 8'h44, 8'h5A, 4'd7);
        get_rsp(8'hF0, 3'b001, 4'd5);
        get_rsp(8'h80, 3'b110, 4'd6);
        get_rsp(8'h5A, 3'b111, 4'd7);
        check("done6", 32'(ops_done), 32'd6);

        // Stall: fill the queue while the consumer holds off
        push(3'b000, 8'h11, 8'h22, 4'd8);
        push(3'b010, 8'hF0, 8'h3C, 4'd9);
        push(3'b011, 8'h0F, 8'h30, 4'd10);
        push(3'b100, 8'hFF, 8'h0F, 4'd11);
        push(3'b101, 8'h5A, 8'h00, 4'd12);
        check("full_rdy", 32'(bus.cmd_ready), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("stall_valid", 32'(bus.rsp_valid), 32'd1);
        check("stall_data",  32'(bus.rsp_data),  32'h33);
        check("stall_tag",   32'(bus.rsp_tag),   32'd8);
        check("stall_rdy",   32'(bus.cmd_ready), 32'd0);
        get_rsp(8'h33, 3'b000, 4'd8);
        check("drain_rdy", 32'(bus.cmd_ready), 32'd1);
        get_rsp(8'h30, 3'b010, 4'd9);
        get_rsp(8'h3F, 3'b011, 4'd10);
        get_rsp(8'hF0, 3'b100, 4'd11);
        get_rsp(8'hA5, 3'b101, 4'd12);
        check("done11", 32'(ops_done), 32'd11);

        // Reset during SETTLE with two commands queued
        push(3'b000, 8'h01, 8'h01, 4'd13);
        push(3'b000, 8'h02, 8'h02, 4'd14);
        push(3'b000, 8'h03, 8'h03, 4'd15);
        rst = 1'b1;
        #1;
        check("mid_rst_rdy", 32'(bus.cmd_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("post_rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("post_rst_rdy",   32'(bus.cmd_ready), 32'd1);
        check("post_rst_done",  32'(ops_done),      32'd0);
        bus.rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check("stale_valid", 32'(bus.rsp_valid), 32'd0);
        check("stale_done",  32'(ops_done),      32'd0);
        push(3'b000, 8'h07, 8'h08, 4'd1);
        get_rsp(8'h0F, 3'b000, 4'd1);
        check("post_rst_cnt", 32'(ops_done), 32'd1);

        // Counter wrap from a preloaded 0xFFFF
        force dut.ops_done_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut.ops_done_q;
        check("preload", 32'(ops_done), 32'hFFFF);
        push(3'b011, 8'h12, 8'h21, 4'd4);
        get_rsp(8'h33, 3'b011, 4'd4);
        check("wrap0", 32'(ops_done), 32'h0000);
        push(3'b001, 8'h00, 8'h01, 4'd9);
        get_rsp(8'hFF, 3'b001, 4'd9);
        check("wrap1", 32'(ops_done), 32'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
